// File: rtl/oser4_feeder_pkg.sv
// rtl/oser4_feeder_pkg.sv - shared widths and sequencer states for the OSER4 feeder
package oser4_feeder_pkg;

  localparam int NIB_W  = 4;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } seq_state_t;

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - registered-state byte FIFO, power-of-two depth
module byte_fifo
  import oser4_feeder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [BYTE_W-1:0] wdata,
  input  logic              pop,
  output logic [BYTE_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [CW-1:0]     cnt_q;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/oser4_feeder.sv
// rtl/oser4_feeder.sv - byte-to-nibble feeder for an OSER4 with PCLK = FCLK/2
module oser4_feeder
  import oser4_feeder_pkg::*;
#(
  parameter int               DEPTH    = 4,
  parameter logic [NIB_W-1:0] IDLE_NIB = 4'b0000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [BYTE_W-1:0] s_data_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  output logic              pclk_o,
  output logic [NIB_W-1:0]  d_o,
  output logic              busy_o,
  output logic              underrun_o
);

  seq_state_t        state_q, state_d;
  logic              pclk_q;
  logic              ready_en_q;
  logic [NIB_W-1:0]  d_q, d_d;
  logic [NIB_W-1:0]  hi_q, hi_d;
  logic              busy_q, busy_d;
  logic              under_q, under_d;
  logic              slot;
  logic              pop;
  logic              push;
  logic              fifo_full;
  logic              fifo_empty;
  logic [BYTE_W-1:0] fifo_rdata;

  // Slot edge: the edge on which pclk goes 0 -> 1.
  assign slot       = !pclk_q;
  // ready_en keeps s_ready_o low during reset and for the release edge.
  assign s_ready_o  = ready_en_q && !fifo_full;
  assign push       = s_valid_i && s_ready_o;
  assign pclk_o     = pclk_q;
  assign d_o        = d_q;
  assign busy_o     = busy_q;
  assign underrun_o = under_q;

  byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (push),
    .wdata (s_data_i),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pclk_q     <= 1'b0;
      ready_en_q <= 1'b0;
      state_q    <= IDLE;
      d_q        <= IDLE_NIB;
      hi_q       <= '0;
      busy_q     <= 1'b0;
      under_q    <= 1'b0;
    end else begin
      pclk_q     <= !pclk_q;
      ready_en_q <= 1'b1;
      state_q    <= state_d;
      d_q        <= d_d;
      hi_q       <= hi_d;
      busy_q     <= busy_d;
      under_q    <= under_d;
    end
  end

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    hi_d    = hi_q;
    busy_d  = busy_q;
    under_d = 1'b0;
    pop     = 1'b0;
    if (slot) begin
      case (state_q)
        LO: begin
          d_d     = hi_q;
          busy_d  = 1'b1;
          state_d = HI;
        end
        default: begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            d_d     = fifo_rdata[NIB_W-1:0];
            hi_d    = fifo_rdata[BYTE_W-1:NIB_W];
            busy_d  = 1'b1;
            state_d = LO;
          end else begin
            d_d     = IDLE_NIB;
            busy_d  = 1'b0;
            under_d = (state_q == HI);
            state_d = IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oser4_feeder.sv
// tb/tb_oser4_feeder.sv - scoreboard bench for oser4_feeder
module tb_oser4_feeder;

  localparam int         DEPTH    = 4;
  localparam logic [3:0] IDLE_NIB = 4'b0000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic       pclk_o;
  logic [3:0] d_o;
  logic       busy_o;
  logic       underrun_o;

  int n_err = 0;
  int n_checks = 0;
  logic [3:0] exp_q[$];
  logic       mon_en = 1'b0;
  logic       pclk_prev = 1'b0;
  logic       busy_prev = 1'b0;
  logic [3:0] d_prev = 4'h0;
  int         busy_cnt = 0;
  int         under_cnt = 0;
  int         acc_cnt = 0;
  int         stall_acc = -1;

  oser4_feeder #(
    .DEPTH    (DEPTH),
    .IDLE_NIB (IDLE_NIB)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .s_data_i   (s_data),
    .s_valid_i  (s_valid),
    .s_ready_o  (s_ready),
    .pclk_o     (pclk_o),
    .d_o        (d_o),
    .busy_o     (busy_o),
    .underrun_o (underrun_o)
  );

  always #5 clk = !clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: sampled on the falling edge, pops the scoreboard at every busy slot.
  always @(negedge clk) begin
    if (mon_en) begin
      check("pclk_toggle", 32'(pclk_o), 32'(!pclk_prev));
      if (pclk_o && !pclk_prev) begin
        if (busy_o) begin
          check("spurious_busy", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) check("nibble", 32'(d_o), 32'(exp_q.pop_front()));
        end else begin
          check("idle_nib", 32'(d_o), 32'(IDLE_NIB));
        end
      end else begin
        check("hold", 32'({busy_o, d_o}), 32'({busy_prev, d_prev}));
      end
      if (busy_o) busy_cnt++;
      if (underrun_o) under_cnt++;
    end
    pclk_prev = pclk_o;
    busy_prev = busy_o;
    d_prev    = d_o;
  end

  task automatic do_reset();
    rst_n  = 1'b0;
    mon_en = 1'b0;
    #1;
    check("rst_pclk", 32'(pclk_o), 32'd0);
    check("rst_d", 32'(d_o), 32'(IDLE_NIB));
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_under", 32'(underrun_o), 32'd0);
    check("rst_ready", 32'(s_ready), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", 32'(s_ready), 32'd0);
    @(posedge clk);
    #1;
    check("ready_after_edge", 32'(s_ready), 32'd1);
    mon_en    = 1'b1;
    busy_cnt  = 0;
    under_cnt = 0;
  endtask

  // Called at a falling edge; leaves s_valid high and returns at the next falling edge.
  task automatic send_byte(input logic [7:0] b);
    logic r;
    int   n;
    r = 1'b0;
    s_data  = b;
    s_valid = 1'b1;
    for (n = 0; n < 200; n++) begin
      r = s_ready;
      if (!r && stall_acc < 0) stall_acc = acc_cnt;
      @(posedge clk);
      if (r) begin
        exp_q.push_back(b[3:0]);
        exp_q.push_back(b[7:4]);
        acc_cnt++;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    check("send_accepted", 32'(r), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy_o) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", 32'(n < 400), 32'd1);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] bytes6 [6];
    int n;
    bytes6 = '{8'h11, 8'h22, 8'h93, 8'h4C, 8'hB5, 8'h6E};

    @(negedge clk);
    do_reset();

    // Idle after reset.
    repeat (20) @(negedge clk);
    check("idle_busy_cnt", 32'(busy_cnt), 32'd0);
    check("idle_under_cnt", 32'(under_cnt), 32'd0);

    // Single byte.
    @(negedge clk);
    busy_cnt = 0; under_cnt = 0;
    send_byte(8'hA5);
    s_valid = 1'b0;
    drain();
    check("a5_busy_cycles", 32'(busy_cnt), 32'd4);
    check("a5_underruns", 32'(under_cnt), 32'd1);

    // Gap-free stream: any idle slot would add busy-low cycles and an extra underrun.
    busy_cnt = 0; under_cnt = 0;
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    s_valid = 1'b0;
    drain();
    check("stream_busy_cycles", 32'(busy_cnt), 32'd12);
    check("stream_underruns", 32'(under_cnt), 32'd1);

    // Fill past full: one pop lands during the fill, so the stall comes after DEPTH+1 accepts.
    busy_cnt = 0; under_cnt = 0; acc_cnt = 0; stall_acc = -1;
    for (int i = 0; i < 6; i++) send_byte(bytes6[i]);
    s_valid = 1'b0;
    drain();
    check("fill_stall_accepts", 32'(stall_acc), 32'(DEPTH + 1));
    check("fill_accepts", 32'(acc_cnt), 32'd6);
    check("fill_busy_cycles", 32'(busy_cnt), 32'd24);
    check("fill_underruns", 32'(under_cnt), 32'd1);

    // Reset while the low nibble of 0xF0 is on d_o.
    send_byte(8'hF0);
    s_valid = 1'b0;
    n = 0;
    while (!(busy_o && d_o == 4'h0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("f0_low_seen", 32'(n < 50), 32'd1);
    #1;
    do_reset();
    repeat (20) @(negedge clk);
    check("post_rst_busy_cnt", 32'(busy_cnt), 32'd0);
    check("post_rst_under_cnt", 32'(under_cnt), 32'd0);

    // Push exactly on a slot edge into an empty FIFO.
    n = 0;
    while (pclk_o != 1'b0 && n < 4) begin
      @(negedge clk);
      n++;
    end
    check("slot_align", 32'(pclk_o), 32'd0);
    check("slot_ready", 32'(s_ready), 32'd1);
    s_data  = 8'h3C;
    s_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(4'hC);
    exp_q.push_back(4'h3);
    @(negedge clk);
    s_valid = 1'b0;
    check("slot_push_idle_busy", 32'(busy_o), 32'd0);
    check("slot_push_idle_d", 32'(d_o), 32'(IDLE_NIB));
    @(negedge clk);
    @(negedge clk);
    check("slot_push_busy", 32'(busy_o), 32'd1);
    check("slot_push_low", 32'(d_o), 32'hC);
    drain();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
